// File: rtl/systolic_skew_feeder.sv
// Buffers one activation tile, then replays it into the systolic array.
// Lane j is delayed j cycles relative to lane 0, and the skew is padded with zeros.

module skew_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);
    logic [STAGES-1:0]                 vld_pipe;
    logic [STAGES-1:0][DATA_WIDTH-1:0] dat_pipe;

    // Data is zeroed on entry so that invalid slots carry 0 down the whole chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[0] <= in_valid;
            dat_pipe[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign out_data  = dat_pipe[STAGES-1];
endmodule

module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4,
    parameter int DEPTH      = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]     s_data,
    input  logic                                 s_last,
    output logic [LANES-1:0][DATA_WIDTH-1:0]     arr_data,
    output logic [LANES-1:0]                     arr_valid,
    output logic                                 busy,
    output logic                                 tile_done,
    output logic [$clog2(DEPTH+1)-1:0]           tile_len
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

    state_t                              state;
    logic [CW-1:0]                       cnt;
    logic [LW-1:0]                       dcnt;
    logic [LANES-1:0][DATA_WIDTH-1:0]    mem [DEPTH];
    logic                                accept;
    logic                                streaming;
    logic                                load_full;
    logic [AW-1:0]                       wr_idx;
    logic [AW-1:0]                       rd_idx;
    logic [LANES-1:0][DATA_WIDTH-1:0]    rd_row;

    assign s_ready   = !rst && (state == IDLE || state == LOAD);
    assign accept    = s_valid && s_ready;
    assign busy      = (state != IDLE);
    assign tile_done = (state == DONE);
    assign streaming = (state == STREAM);
    assign load_full = (cnt == CW'(DEPTH - 1));

    assign wr_idx = (state == IDLE) ? '0 : cnt[AW-1:0];
    assign rd_idx = cnt[AW-1:0];
    assign rd_row = mem[rd_idx];

    // The tile buffer holds no reset: its contents are only read after a full load.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_idx] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            dcnt     <= '0;
            tile_len <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (s_last || DEPTH == 1) begin
                            tile_len <= CW'(1);
                            cnt      <= '0;
                            state    <= STREAM;
                        end else begin
                            cnt   <= CW'(1);
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (s_last || load_full) begin
                            tile_len <= cnt + CW'(1);
                            cnt      <= '0;
                            state    <= STREAM;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                // cnt doubles as the read row index while streaming.
                STREAM: begin
                    if (cnt == tile_len - CW'(1)) begin
                        cnt   <= '0;
                        state <= (LANES == 1) ? DONE : DRAIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (dcnt == LW'(LANES - 2)) begin
                        dcnt  <= '0;
                        state <= DONE;
                    end else begin
                        dcnt <= dcnt + LW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        skew_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .STAGES    (j + 1)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .in_valid (streaming),
            .in_data  (rd_row[j]),
            .out_valid(arr_valid[j]),
            .out_data (arr_data[j])
        );
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for the weight-stationary systolic array. It accepts an activation tile as a stream of row vectors over a valid/ready handshake and buffers the whole tile. It then replays the tile into the array's per-column `input_data` ports with the diagonal skew the array needs: lane j is delayed j cycles relative to lane 0. It pads the skew with zeros and reports tile completion once the last skewed element has been presented.

## Interface
- `DATA_WIDTH`, 32: width of one activation element.
- `LANES`, 4: number of array input lanes; equals the array's activation column count.
- `DEPTH`, 8: maximum vectors per tile (buffer rows); must be ≥1.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high; clears all state.
- `s_valid`  in  1: upstream vector valid.
- `s_ready`  out  1: feeder can accept a vector.
- `s_data`  in  LANES×DATA_WIDTH: row vector; element j targets lane j.
- `s_last`  in  1: marks the final vector of the tile.
- `arr_data`  out  LANES×DATA_WIDTH: skewed lane data to the array; registered.
- `arr_valid`  out  LANES: per-lane marker; 1 when `arr_data[j]` carries a tile element, else `arr_data[j]` is 0.
- `busy`  out  1: high in every state except IDLE.
- `tile_done`  out  1: one-cycle pulse at the end of a tile.
- `tile_len`  out  $clog2(DEPTH+1): length of the current or last tile.

## Operation
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- **IDLE**
  - `s_ready`=1.
  - The first accepted beat (`s_valid`&&`s_ready`) is written to row 0, count is set to 1, and the FSM moves to LOAD.
  - If that beat has `s_last`, or DEPTH==1, the FSM instead moves to STREAM with `tile_len`=1.
- **LOAD**
  - `s_ready`=1. Each accepted beat is written to row `count`, then `count` is incremented.
  - An accepted beat with `s_last`=1 closes the tile: `tile_len`=count+1, next state STREAM.
  - An accepted beat that fills row DEPTH-1 closes the tile with `tile_len`=DEPTH even if `s_last`=0. The next beat starts a new tile.
- **STREAM**
  - `s_ready`=0.
  - On stream cycle c (0..`tile_len`-1), row c is read and element j enters skew line j.
  - After cycle `tile_len`-1, the FSM moves to DRAIN. If LANES==1, it moves directly to DONE.
- **DRAIN**
  - Lasts LANES-1 cycles, with zeros and valid=0 entering every skew line. Then the FSM moves to DONE.
- **DONE**
  - `tile_done`=1 for this one cycle, `s_ready`=0, next state IDLE.
- **Skew lines**
  - Lane j is a shift chain of j+1 registers carrying {valid, data}. Lane 0 is a single output register.
  - `arr_data[j]`/`arr_valid[j]` are driven from the last register of lane j.
  - Invalid slots always carry data 0.
- No back-pressure from the array: once STREAM starts, the feeder runs free to DONE.
- Data is passed through unmodified; no arithmetic on elements. `tile_len` range is 1..DEPTH.

## Timing
- **Reset values:** all registered outputs are 0 while `rst` is high: `arr_data`=0, `arr_valid`=0, `busy`=0, `tile_done`=0, `tile_len`=0. `s_ready`=0 while `rst` is asserted, and 1 in the first cycle after deassertion (IDLE).
- **Reset mid-tile:** any state returns to IDLE. Buffer contents are don't-care. All skew registers clear immediately, so no partial tile reaches the array.
- **Stream timing.** Let S = the first STREAM cycle, i.e. the cycle after the closing beat is accepted.
  - Element (row c, lane j) is visible on `arr_data[j]` during cycle S+c+1+j.
  - `arr_valid[j]` is high for exactly `tile_len` consecutive cycles, S+1+j .. S+`tile_len`+j.
- **DONE timing:** DONE, and therefore `tile_done`, is at cycle S+`tile_len`+LANES-1. This coincides with the last element on lane LANES-1.
- **Tile-to-tile timing:**
  - `s_ready` returns to 1 in cycle S+`tile_len`+LANES.
  - A new tile's first beat can be accepted in that cycle.
  - Tile-to-tile period: `tile_len` (load, one beat per cycle) + `tile_len`+LANES (stream+drain+done).
- **Load timing:** `s_ready` is combinational from state only, never from `s_valid`. Beats with `s_valid`=0 in LOAD are simply waited on, with no timeout.
- **Handshake while not ready:** `s_last` and `s_data` are ignored when `s_valid`&&`s_ready` is false.

## Test plan
- **Reset values:** hold `rst` mid-STREAM of a 4-row tile → all outputs 0 immediately. After release, `s_ready`=1, `busy`=0, and no valid lane data appears.
- **Basic skew:** LANES=4, tile of 3 rows with row c = {10c+0, 10c+1, 10c+2, 10c+3}, `s_last` on row 2.
  - `arr_data[j]` shows 10c+j at S+c+1+j.
  - `tile_done` at S+6.
  - `s_ready` back at S+7.
- **Single-row tile:** one beat {5,6,7,8} with `s_last`.
  - `tile_len`=1.
  - Lanes see 5,6,7,8 at S+1..S+4 respectively.
  - `tile_done` at S+4.
- **Depth overflow:** DEPTH=8; send 10 beats with `s_last` only on beat 9.
  - First tile has `tile_len`=8 and streams beats 0..7.
  - Beats 8–9 form a second tile with `tile_len`=2 after the first tile's DONE.
- **Gapped load:** `s_valid` toggles 1,0,0,1,1(last).
  - Exactly 3 rows are captured, in order.
  - `s_ready`=0 throughout STREAM, DRAIN and DONE.
  - Beats offered during STREAM are not accepted.
- **Back-to-back tiles:** hold `s_valid`=1 continuously. Check that the second tile's first beat is accepted exactly in the first cycle after `tile_done`, and that `arr_valid` windows of consecutive tiles never overlap.
